// File: rtl/hwpe_tcdm_req_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : hwpe_tcdm_req_buffer
//  Description : Per-port request buffer between an HWPE streamer (engine
//                side) and the flat TCDM master bus. Each port has a
//                registered request FIFO (no fall-through) and an
//                outstanding-read limiter. Responses pass straight through.
//
//  Ports (all per-port signals are flat vectors, port p at slice p):
//    clk_i, rst_ni      clock, asynchronous active-low reset
//    clear_i            synchronous flush of all request FIFOs
//    in_*               engine-side request / grant / response
//    tcdm_*             bus-side request / grant / response
//    busy_o             FIFO non-empty or reads still outstanding
//    err_o              sticky: read response seen with nothing outstanding
//    perf_stall_o       (optional) per-port 32-bit stall-cycle counters
//
//  Optional feature : define HWPE_TCDM_REQ_BUFFER_PERF_EN to add perf_stall_o.
//  Revision         : 1.0 - initial release
// ============================================================================
module hwpe_tcdm_req_buffer #(
    parameter int N_PORTS         = 3,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            clear_i,
    input  logic [N_PORTS-1:0]              in_req,
    output logic [N_PORTS-1:0]              in_gnt,
    input  logic [N_PORTS*ADDR_WIDTH-1:0]   in_add,
    input  logic [N_PORTS-1:0]              in_wen,
    input  logic [N_PORTS*DATA_WIDTH/8-1:0] in_be,
    input  logic [N_PORTS*DATA_WIDTH-1:0]   in_data,
    output logic [N_PORTS*DATA_WIDTH-1:0]   in_r_data,
    output logic [N_PORTS-1:0]              in_r_valid,
    output logic [N_PORTS-1:0]              tcdm_req,
    input  logic [N_PORTS-1:0]              tcdm_gnt,
    output logic [N_PORTS*ADDR_WIDTH-1:0]   tcdm_add,
    output logic [N_PORTS-1:0]              tcdm_wen,
    output logic [N_PORTS*DATA_WIDTH/8-1:0] tcdm_be,
    output logic [N_PORTS*DATA_WIDTH-1:0]   tcdm_data,
    input  logic [N_PORTS*DATA_WIDTH-1:0]   tcdm_r_data,
    input  logic [N_PORTS-1:0]              tcdm_r_valid,
`ifdef HWPE_TCDM_REQ_BUFFER_PERF_EN
    output logic [N_PORTS*32-1:0]           perf_stall_o,
`endif
    output logic [N_PORTS-1:0]              busy_o,
    output logic [N_PORTS-1:0]              err_o
);

    localparam int BE_W    = DATA_WIDTH / 8;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    // FIFO entry layout, MSB first: {add, wen, be, data}
    localparam int ENTRY_W = ADDR_WIDTH + 1 + BE_W + DATA_WIDTH;
    localparam int WEN_POS = BE_W + DATA_WIDTH;

    localparam logic [PTR_W:0]   C_PTR_ONE = (PTR_W + 1)'(1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    // Response path is a pure pass-through; TCDM returns data in issue order.
    assign in_r_data  = tcdm_r_data;
    assign in_r_valid = tcdm_r_valid;

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        logic [ENTRY_W-1:0] mem_q [DEPTH];
        logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
        logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
        logic [CNT_W-1:0]   cnt_q, cnt_d;
        logic               err_q, err_d;
        logic [ENTRY_W-1:0] head;
        logic               empty, full, head_wen, req, gnt, push, pop, read_pop;

        assign empty = (wr_ptr_q == rd_ptr_q);
        // Same slot index but different wrap bit: writer is a full lap ahead.
        assign full  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                       (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);

        assign head     = mem_q[rd_ptr_q[PTR_W-1:0]];
        assign head_wen = head[WEN_POS];

        // Writes are never throttled; a read at the head waits for a free
        // outstanding slot and so holds back everything queued behind it.
        assign req      = !empty && (!head_wen || (cnt_q < C_CNT_MAX));
        // Grant depends on state and clear only, never on in_req or tcdm_gnt.
        assign gnt      = !full && !clear_i;
        assign push     = in_req[p] && gnt;
        assign pop      = req && tcdm_gnt[p];
        assign read_pop = pop && head_wen;

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            err_d    = err_q;

            if (clear_i) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
            end else begin
                if (push) wr_ptr_d = wr_ptr_q + C_PTR_ONE;
                if (pop)  rd_ptr_d = rd_ptr_q + C_PTR_ONE;
            end

            // Outstanding count survives clear_i so late responses still
            // retire; a read granted in the clear cycle still counts.
            if (tcdm_r_valid[p] && (cnt_q == '0)) begin
                err_d = 1'b1;
            end
            if (read_pop && !tcdm_r_valid[p]) begin
                cnt_d = cnt_q + C_CNT_ONE;
            end else if (!read_pop && tcdm_r_valid[p] && (cnt_q != '0)) begin
                cnt_d = cnt_q - C_CNT_ONE;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
                err_q    <= 1'b0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
                err_q    <= err_d;
            end
        end

        // Storage needs no reset: contents are only visible when non-empty.
        always_ff @(posedge clk_i) begin
            if (push) begin
                mem_q[wr_ptr_q[PTR_W-1:0]] <= {in_add[p*ADDR_WIDTH +: ADDR_WIDTH],
                                               in_wen[p],
                                               in_be[p*BE_W +: BE_W],
                                               in_data[p*DATA_WIDTH +: DATA_WIDTH]};
            end
        end

        assign in_gnt[p]                            = gnt;
        assign tcdm_req[p]                          = req;
        assign tcdm_add[p*ADDR_WIDTH +: ADDR_WIDTH] = head[ENTRY_W-1 -: ADDR_WIDTH];
        assign tcdm_wen[p]                          = head_wen;
        assign tcdm_be[p*BE_W +: BE_W]              = head[DATA_WIDTH +: BE_W];
        assign tcdm_data[p*DATA_WIDTH +: DATA_WIDTH] = head[DATA_WIDTH-1:0];
        assign busy_o[p]                            = !empty || (cnt_q != '0);
        assign err_o[p]                             = err_q;

`ifdef HWPE_TCDM_REQ_BUFFER_PERF_EN
        logic [31:0] perf_q, perf_d;

        always_comb begin
            perf_d = perf_q;
            if (clear_i) begin
                perf_d = '0;
            end else if (req && !tcdm_gnt[p] && (perf_q != 32'hFFFF_FFFF)) begin
                perf_d = perf_q + 32'd1;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                perf_q <= '0;
            end else begin
                perf_q <= perf_d;
            end
        end

        assign perf_stall_o[p*32 +: 32] = perf_q;
`endif
    end : g_port

endmodule
`default_nettype wire

// File: tb/tb_hwpe_tcdm_req_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hwpe_tcdm_req_buffer
//  Description : Self-checking bench for hwpe_tcdm_req_buffer
//                (N_PORTS=3, 32-bit address/data, DEPTH=4, MAX_OUTSTANDING=2).
//                A queue-based reference model is compared every cycle and
//                directed scenarios add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hwpe_tcdm_req_buffer;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    typedef struct packed {
        logic [AW-1:0] add;
        logic          wen;
        logic [BW-1:0] be;
        logic [DW-1:0] data;
    } ent_t;

    logic              clk, rst_n, clear_i;
    logic [N-1:0]      in_req, in_gnt, in_wen, in_r_valid;
    logic [N*AW-1:0]   in_add, tcdm_add;
    logic [N*BW-1:0]   in_be, tcdm_be;
    logic [N*DW-1:0]   in_data, in_r_data, tcdm_data, tcdm_r_data;
    logic [N-1:0]      tcdm_req, tcdm_gnt, tcdm_wen, tcdm_r_valid, busy_o, err_o;
`ifdef HWPE_TCDM_REQ_BUFFER_PERF_EN
    logic [N*32-1:0]   perf_stall_o;
`endif

    hwpe_tcdm_req_buffer #(
        .N_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_i),
        .in_req(in_req), .in_gnt(in_gnt), .in_add(in_add), .in_wen(in_wen),
        .in_be(in_be), .in_data(in_data), .in_r_data(in_r_data),
        .in_r_valid(in_r_valid), .tcdm_req(tcdm_req), .tcdm_gnt(tcdm_gnt),
        .tcdm_add(tcdm_add), .tcdm_wen(tcdm_wen), .tcdm_be(tcdm_be),
        .tcdm_data(tcdm_data), .tcdm_r_data(tcdm_r_data),
        .tcdm_r_valid(tcdm_r_valid),
`ifdef HWPE_TCDM_REQ_BUFFER_PERF_EN
        .perf_stall_o(perf_stall_o),
`endif
        .busy_o(busy_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int p,
                         input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s port%0d @%0t: got %0h, expected %0h",
                     name, p, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    ent_t        mq [N][$];
    int          mout [N];
    logic        merr [N];
    logic [31:0] mperf [N];

    function automatic bit m_req(int p);
        if (mq[p].size() == 0) return 1'b0;
        return !mq[p][0].wen || (mout[p] < MAXO);
    endfunction

    function automatic bit m_gnt(int p);
        return (mq[p].size() < DEPTH) && !clear_i;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < N; p++) begin
                mq[p].delete();
                mout[p]  = 0;
                merr[p]  = 1'b0;
                mperf[p] = '0;
            end
        end else begin
            for (int p = 0; p < N; p++) begin
                bit   rq, pp, rp, ps;
                ent_t e;
                rq = m_req(p);
                pp = rq && tcdm_gnt[p];
                rp = pp && mq[p][0].wen;
                ps = in_req[p] && m_gnt(p);
                if (clear_i) mperf[p] = '0;
                else if (rq && !tcdm_gnt[p] && mperf[p] != 32'hFFFF_FFFF)
                    mperf[p] = mperf[p] + 1;
                if (clear_i) begin
                    mq[p].delete();
                end else begin
                    if (pp) void'(mq[p].pop_front());
                    if (ps) begin
                        e.add  = in_add[p*AW +: AW];
                        e.wen  = in_wen[p];
                        e.be   = in_be[p*BW +: BW];
                        e.data = in_data[p*DW +: DW];
                        mq[p].push_back(e);
                    end
                end
                if (tcdm_r_valid[p] && mout[p] == 0) merr[p] = 1'b1;
                if (rp && !tcdm_r_valid[p]) mout[p]++;
                else if (!rp && tcdm_r_valid[p] && mout[p] > 0) mout[p]--;
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < N; p++) begin
                bit er;
                er = m_req(p);
                check("in_gnt",   p, in_gnt[p],   m_gnt(p));
                check("tcdm_req", p, tcdm_req[p], er);
                check("busy_o",   p, busy_o[p],   (mq[p].size() > 0) || (mout[p] != 0));
                check("err_o",    p, err_o[p],    merr[p]);
                check("in_r_valid", p, in_r_valid[p], tcdm_r_valid[p]);
                check("in_r_data",  p, in_r_data[p*DW +: DW], tcdm_r_data[p*DW +: DW]);
                if (er) begin
                    check("tcdm_add",  p, tcdm_add[p*AW +: AW],  mq[p][0].add);
                    check("tcdm_wen",  p, tcdm_wen[p],           mq[p][0].wen);
                    check("tcdm_be",   p, tcdm_be[p*BW +: BW],   mq[p][0].be);
                    check("tcdm_data", p, tcdm_data[p*DW +: DW], mq[p][0].data);
                end
`ifdef HWPE_TCDM_REQ_BUFFER_PERF_EN
                check("perf_stall", p, perf_stall_o[p*32 +: 32], mperf[p]);
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic r, input logic [31:0] a,
                           input logic w, input logic [3:0] b, input logic [31:0] d);
        in_req[p]          = r;
        in_add[p*AW +: AW] = a;
        in_wen[p]          = w;
        in_be[p*BW +: BW]  = b;
        in_data[p*DW +: DW] = d;
    endtask

    initial begin
        rst_n = 1'b0; clear_i = 1'b0;
        in_req = '0; in_add = '0; in_wen = '0; in_be = '0; in_data = '0;
        tcdm_gnt = '0; tcdm_r_valid = '0; tcdm_r_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_tcdm_req", 0, tcdm_req, 3'b000);
        check("rst_busy",     0, busy_o,   3'b000);
        check("rst_err",      0, err_o,    3'b000);
        check("rst_in_gnt",   0, in_gnt,   3'b111);

        // 1) four writes on port 0, bus always granting
        tcdm_gnt[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1'b1, 32'h1000 + 4*i, 1'b0, 4'hF, 32'hA0 + i);
            if (i == 0) begin
                #1 check("no_fallthrough", 0, tcdm_req[0], 1'b0);
            end
            tick();
            if (i == 0) begin
                check("first_issue_req", 0, tcdm_req[0], 1'b1);
                check("first_issue_add", 0, tcdm_add[31:0], 32'h1000);
            end
        end
        in_req[0] = 1'b0;
        check("last_head_data", 0, tcdm_data[31:0], 32'hA3);
        tick();
        check("drained_busy", 0, busy_o[0], 1'b0);
        tcdm_gnt[0] = 1'b0;

        // 2) port 1 backpressure: five writes into a 4-deep FIFO
        for (int i = 0; i < 5; i++) begin
            set_req(1, 1'b1, 32'h2000 + 4*i, 1'b0, 4'h3, 32'hB0 + i);
            tick();
        end
        check("full_gnt",       1, in_gnt[1], 1'b0);
        check("full_head_add",  1, tcdm_add[63:32],  32'h2000);
        check("full_head_data", 1, tcdm_data[63:32], 32'hB0);
        tick();
        check("stable_head_add", 1, tcdm_add[63:32], 32'h2000);
        tcdm_gnt[1] = 1'b1;
        #1 check("full_gnt_ignores_bus", 1, in_gnt[1], 1'b0);
        tick();
        check("after_pop_gnt", 1, in_gnt[1], 1'b1);
        check("after_pop_add", 1, tcdm_add[63:32], 32'h2004);
        tick();
        in_req[1] = 1'b0;
        repeat (5) tick();
        check("p1_drained", 1, busy_o[1], 1'b0);
        tcdm_gnt[1] = 1'b0;

        // 3) port 2 outstanding limit (MAX_OUTSTANDING = 2)
        tcdm_gnt[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_req(2, 1'b1, 32'h3000 + 4*i, 1'b1, 4'hF, 32'h0);
            tick();
        end
        in_req[2] = 1'b0;
        check("limit_blocks_req", 2, tcdm_req[2], 1'b0);
        check("limit_head_add",   2, tcdm_add[95:64], 32'h3008);
        tcdm_r_valid[2] = 1'b1;
        tcdm_r_data[95:64] = 32'hDEAD_BEEF;
        #1;
        check("resp_valid_fwd", 2, in_r_valid[2], 1'b1);
        check("resp_data_fwd",  2, in_r_data[95:64], 32'hDEAD_BEEF);
        tick();
        tcdm_r_valid[2] = 1'b0;
        check("limit_released", 2, tcdm_req[2], 1'b1);
        tick();
        tcdm_r_valid[2] = 1'b1;
        repeat (2) tick();
        tcdm_r_valid[2] = 1'b0;
        check("p2_idle", 2, busy_o[2], 1'b0);
        // read pop coinciding with a response at outstanding = 1
        set_req(2, 1'b1, 32'h3100, 1'b1, 4'hF, 32'h0);
        tick();
        in_req[2] = 1'b0;
        tick();
        set_req(2, 1'b1, 32'h3104, 1'b1, 4'hF, 32'h0);
        tick();
        in_req[2] = 1'b0;
        tcdm_r_valid[2] = 1'b1;
        tick();
        tcdm_r_valid[2] = 1'b0;
        check("same_cycle_busy", 2, busy_o[2], 1'b1);
        tcdm_r_valid[2] = 1'b1;
        tick();
        tcdm_r_valid[2] = 1'b0;
        check("one_left_idle", 2, busy_o[2], 1'b0);
        // spurious response
        tcdm_r_valid[2] = 1'b1;
        tick();
        tcdm_r_valid[2] = 1'b0;
        check("spurious_err",  2, err_o[2],  1'b1);
        check("spurious_busy", 2, busy_o[2], 1'b0);
        tcdm_gnt[2] = 1'b0;

        // 4) clear with one read outstanding and three queued writes
        tcdm_gnt[0] = 1'b1;
        set_req(0, 1'b1, 32'h4000, 1'b1, 4'hF, 32'h0);
        tick();
        in_req[0] = 1'b0;
        tick();
        tcdm_gnt[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1'b1, 32'h4010 + 4*i, 1'b0, 4'h1, 32'hC0 + i);
            tick();
        end
        in_req[0] = 1'b0;
        clear_i = 1'b1;
        #1;
        check("clear_gnt",      0, in_gnt, 3'b000);
        check("clear_req_held", 0, tcdm_req[0], 1'b1);
        tick();
        clear_i = 1'b0;
        check("cleared_req",  0, tcdm_req[0], 1'b0);
        check("cleared_busy", 0, busy_o[0], 1'b1);
        tcdm_r_valid[0] = 1'b1;
        tcdm_r_data[31:0] = 32'h1234_5678;
        #1 check("late_resp_fwd", 0, in_r_valid[0], 1'b1);
        tick();
        tcdm_r_valid[0] = 1'b0;
        check("late_resp_idle", 0, busy_o[0], 1'b0);
        check("no_err_p0",      0, err_o[0], 1'b0);

        // 5) stall counting on port 1
        set_req(1, 1'b1, 32'h5000, 1'b0, 4'hF, 32'h55);
        tick();
        in_req[1] = 1'b0;
        repeat (7) tick();
`ifdef HWPE_TCDM_REQ_BUFFER_PERF_EN
        check("perf_seven", 1, perf_stall_o[63:32], 32'd7);
`endif
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
`ifdef HWPE_TCDM_REQ_BUFFER_PERF_EN
        check("perf_cleared", 1, perf_stall_o[63:32], 32'd0);
`endif
        check("p1_cleared_busy", 1, busy_o[1], 1'b0);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hwpe_tcdm_req_buffer.md
Name: hwpe_tcdm_req_buffer

Overview:
- Parametrised per-port request buffer between an HWPE streamer (engine side) and the flat TCDM master bus of a wrapper.
- Generalises the fixed 3-port flat TCDM mapping: any port count, any address and data width.
- Each port gets a registered request FIFO and an outstanding-read limiter.
- Decouples engine request timing from interconnect grant latency.

Parameters:
- N_PORTS, 3, number of TCDM ports (operands + results).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width. Must be a multiple of 8.
- DEPTH, 4, request FIFO entries per port. Power of two, ≥2.
- MAX_OUTSTANDING, 4, maximum issued-but-unanswered reads per port, ≥1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous flush of all request FIFOs.
- in_req  in  N_PORTS  engine request.
- in_gnt  out  N_PORTS  engine grant (FIFO accept).
- in_add  in  N_PORTS×ADDR_WIDTH  engine address.
- in_wen  in  N_PORTS  1 = read, 0 = write (TCDM convention).
- in_be  in  N_PORTS×DATA_WIDTH/8  byte enables.
- in_data  in  N_PORTS×DATA_WIDTH  write data.
- in_r_data  out  N_PORTS×DATA_WIDTH  read data to engine.
- in_r_valid  out  N_PORTS  read-data valid to engine.
- tcdm_req  out  N_PORTS  bus request.
- tcdm_gnt  in  N_PORTS  bus grant.
- tcdm_add  out  N_PORTS×ADDR_WIDTH  bus address.
- tcdm_wen  out  N_PORTS  bus wen.
- tcdm_be  out  N_PORTS×DATA_WIDTH/8  bus byte enables.
- tcdm_data  out  N_PORTS×DATA_WIDTH  bus write data.
- tcdm_r_data  in  N_PORTS×DATA_WIDTH  bus read data.
- tcdm_r_valid  in  N_PORTS  bus read valid.
- busy_o  out  N_PORTS  FIFO non-empty OR outstanding ≠ 0.
- err_o  out  N_PORTS  sticky: tcdm_r_valid seen with outstanding = 0.

Behaviour:
- Clock and reset: single clock clk_i. Reset is asynchronous and active-low on rst_ni.
- Reset values: all FIFOs empty; outstanding counters = 0; err_o = 0; tcdm_req = 0; busy_o = 0; in_gnt = 1 once the reset is released.
- Ports are fully independent. All rules below apply per port p.
- Accept:
  - in_gnt[p] = !full[p] && !clear_i.
  - A push occurs when in_req[p] && in_gnt[p] and stores {add, wen, be, data}.
  - in_gnt is combinational from state and clear_i only, never from in_req.
- Issue:
  - Head entry is driven on the tcdm_* fields.
  - tcdm_req[p] = !empty[p] && (head_wen == 0 || outstanding[p] < MAX_OUTSTANDING).
  - Fields stay stable while tcdm_req = 1 and tcdm_gnt = 0.
  - A pop occurs when tcdm_req && tcdm_gnt.
  - No fall-through: a request pushed in cycle t can raise tcdm_req no earlier than cycle t+1.
- Full FIFO: push and pop in the same cycle are allowed, so throughput is 1 request/cycle. in_gnt is still 0 while full, because in_gnt does not depend on tcdm_gnt.
- Order: FIFO order is preserved per port. Writes are never blocked by the outstanding limit. A read at the head that is blocked by the limit also blocks any writes behind it.
- Outstanding counter:
  - +1 on a read pop.
  - −1 on tcdm_r_valid.
  - Both in the same cycle: no change.
  - Saturates at 0 on a spurious r_valid and sets err_o[p]. err_o clears only on reset.
- Response path:
  - in_r_data = tcdm_r_data and in_r_valid = tcdm_r_valid, combinational, zero latency.
  - Responses return in issue order (TCDM guarantee).
- clear_i:
  - Next edge: FIFO pointers go to empty. tcdm_req is 0 from that edge on; tcdm_req itself is not masked during the clear_i cycle, so a pop granted in that cycle still completes.
  - The outstanding counter is NOT cleared. Pending responses are still forwarded and still decrement the counter.
  - A grant in the clear_i cycle for a read counts as outstanding.
- Pointers: log2(DEPTH) bits plus a wrap bit. Full when the indices match and the wrap bits differ.
- Counter width: $clog2(MAX_OUTSTANDING+1).

Optional Feature:
- Macro: HWPE_TCDM_REQ_BUFFER_PERF_EN.
- When defined, adds output port perf_stall_o (N_PORTS×32). Per-port counter increments every cycle with tcdm_req && !tcdm_gnt. It saturates at 0xFFFFFFFF, resets to 0, and is cleared by clear_i.
- When not defined, the port and counters are absent. All other behaviour is identical.

Test Plan:
- Reset, then push 4 writes on port 0 with tcdm_gnt=1 → tcdm_req rises one cycle after the first push; 4 pops in consecutive cycles; add/data match in order; busy_o[0] falls after the last pop.
- DEPTH=4, tcdm_gnt=0, 5 requests on port 1 → in_gnt[1]=0 after the 4th push; the 5th is held; the head fields stay stable.
- MAX_OUTSTANDING=2, 3 reads granted immediately with no r_valid → 2 issued, third head holds tcdm_req=0. One r_valid → the third issues next cycle.
- Read pop and tcdm_r_valid in the same cycle with outstanding=1 → counter stays 1. Spurious r_valid at outstanding=0 → err_o=1, counter stays 0.
- 3 queued entries, 1 read outstanding, pulse clear_i → FIFO empty, tcdm_req=0; the late r_valid is forwarded to in_r_valid and busy_o then goes 0.
- With HWPE_TCDM_REQ_BUFFER_PERF_EN defined, hold tcdm_gnt=0 for 7 cycles with a pending request → perf_stall_o[p]=7; after clear_i it reads 0.
